// File: rtl/spi_cmd_decoder_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the SPI command decoder: FSM encoding, module
// select codes, command-byte layout and small decode helpers.
package spi_cmd_decoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_FETCH,
        ST_WAIT_DATA,
        ST_DATA,
        ST_LOAD,
        ST_DONE
    } state_t;

    // Module select codes carried in the command byte
    localparam logic [1:0] MOD_SYS_CTRL = 2'd0;
    localparam logic [1:0] MOD_IO_CTRL  = 2'd1;
    localparam logic [1:0] MOD_SMI_CTRL = 2'd2;
    localparam logic [1:0] MOD_RESERVED = 2'd3;

    // Command byte field positions
    localparam int CMD_RD_BIT  = 7;
    localparam int CMD_SEL_MSB = 6;
    localparam int CMD_SEL_LSB = 5;
    localparam int CMD_IOC_MSB = 4;
    localparam int CMD_IOC_LSB = 0;

    // Bit-counter value seen on the last rise of each byte (count before increment)
    localparam logic [4:0] CNT_CMD_LAST  = 5'd7;
    localparam logic [4:0] CNT_DATA_LAST = 5'd15;
    // MISO shifts on falls once the 9th rise has been counted
    localparam logic [4:0] CNT_TX_SHIFT  = 5'd9;

    typedef struct packed {
        logic       rd;
        logic [1:0] sel;
        logic [4:0] ioc;
    } cmd_t;

    function automatic cmd_t decode_cmd(input logic [7:0] b);
        cmd_t c;
        c.rd  = b[CMD_RD_BIT];
        c.sel = b[CMD_SEL_MSB:CMD_SEL_LSB];
        c.ioc = b[CMD_IOC_MSB:CMD_IOC_LSB];
        return c;
    endfunction

    function automatic logic [3:0] sel_onehot(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/spi_cmd_decoder_sync_edge_det.sv
`timescale 1ns/1ps
// Multi-flop synchroniser for one asynchronous input plus rise/fall
// detection on the synchronised level. All instances share the same
// latency, so the relative timing of SCK, MOSI and CS_B is preserved.
module sync_edge_det #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_sys_clk,
    input  logic i_rst_b,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the async input through the chain; keep one extra flop for edges
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], i_async};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign o_sync = sync_q[STAGES-1];
    assign o_rise = o_sync & ~prev_q;
    assign o_fall = ~o_sync & prev_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
`timescale 1ns/1ps
// SPI mode-0 slave that decodes a two-byte frame (command, data) into
// register fetch/load strobes towards four modules, and returns read data
// on MISO during the second byte.
module spi_cmd_decoder
    import spi_cmd_decoder_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_sys_clk,
    input  logic       i_rst_b,
    input  logic       i_spi_sck,
    input  logic       i_spi_mosi,
    input  logic       i_spi_cs_b,
    output logic       o_spi_miso,
    output logic [4:0] o_ioc,
    output logic [3:0] o_cs,
    output logic       o_fetch_cmd,
    output logic       o_load_cmd,
    output logic [7:0] o_data_out,
    input  logic [7:0] i_data_m0,
    input  logic [7:0] i_data_m1,
    input  logic [7:0] i_data_m2,
    input  logic [7:0] i_data_m3
);

    logic sck_q, sck_rise, sck_fall;
    logic mosi_q, mosi_rise, mosi_fall;
    logic cs_q, cs_rise, cs_fall;
    logic sync_unused;

    sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .i_sys_clk(i_sys_clk), .i_rst_b(i_rst_b), .i_async(i_spi_sck),
        .o_sync(sck_q), .o_rise(sck_rise), .o_fall(sck_fall));
    sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .i_sys_clk(i_sys_clk), .i_rst_b(i_rst_b), .i_async(i_spi_mosi),
        .o_sync(mosi_q), .o_rise(mosi_rise), .o_fall(mosi_fall));
    sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .i_sys_clk(i_sys_clk), .i_rst_b(i_rst_b), .i_async(i_spi_cs_b),
        .o_sync(cs_q), .o_rise(cs_rise), .o_fall(cs_fall));

    assign sync_unused = &{sck_q, mosi_rise, mosi_fall, cs_fall};

    state_t           state_q, state_d;
    logic [4:0]       bit_cnt_q;
    logic [6:0]       rx_q;
    logic [7:0]       rx_byte;
    cmd_t             cmd_nxt;
    logic             rd_q;
    logic [1:0]       sel_q;
    logic             wait_q;
    logic [7:0]       tx_q;
    logic [3:0][7:0]  mod_data;
    logic [SYNC_STAGES:0] vld_pipe;
    logic             armed_q;

    assign rx_byte    = {rx_q, mosi_q};
    assign cmd_nxt    = decode_cmd(rx_byte);
    assign mod_data   = {i_data_m3, i_data_m2, i_data_m1, i_data_m0};
    assign o_spi_miso = tx_q[7];

    // After reset, only accept a frame once CS_B has been seen high through a
    // flushed synchroniser, so a frame cut by reset is never resumed.
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            vld_pipe <= '0;
            armed_q  <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
            if (vld_pipe[SYNC_STAGES] && cs_q)
                armed_q <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state and single-cycle strobes; CS_B rise aborts from anywhere
    always_comb begin
        state_d     = state_q;
        o_fetch_cmd = 1'b0;
        o_load_cmd  = 1'b0;
        case (state_q)
            ST_IDLE:      if (armed_q && !cs_q) state_d = ST_CMD;
            ST_CMD:       if (sck_rise && bit_cnt_q == CNT_CMD_LAST)
                              state_d = cmd_nxt.rd ? ST_FETCH : ST_DATA;
            ST_FETCH: begin
                o_fetch_cmd = 1'b1;
                state_d     = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: if (wait_q) state_d = ST_DATA;
            ST_DATA:      if (sck_rise && bit_cnt_q == CNT_DATA_LAST)
                              state_d = rd_q ? ST_DONE : ST_LOAD;
            ST_LOAD: begin
                o_load_cmd = 1'b1;
                state_d    = ST_DONE;
            end
            ST_DONE:      state_d = ST_DONE;
            default:      state_d = ST_IDLE;
        endcase
        if (cs_rise) state_d = ST_IDLE;
    end

    // Frame datapath: bit counter, MOSI capture, command latch, MISO shifter
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            rd_q       <= 1'b0;
            sel_q      <= '0;
            wait_q     <= 1'b0;
            tx_q       <= '0;
            o_ioc      <= '0;
            o_cs       <= '0;
            o_data_out <= '0;
        end else begin
            wait_q <= (state_q == ST_WAIT_DATA) ? ~wait_q : 1'b0;
            if (cs_rise || state_q == ST_IDLE) begin
                bit_cnt_q <= '0;
                o_cs      <= '0;
                tx_q      <= '0;
            end else begin
                if (sck_rise && state_q inside {ST_CMD, ST_FETCH, ST_WAIT_DATA, ST_DATA}) begin
                    rx_q      <= rx_byte[6:0];
                    bit_cnt_q <= bit_cnt_q + 5'd1;
                end
                if (state_q == ST_CMD && sck_rise && bit_cnt_q == CNT_CMD_LAST) begin
                    rd_q  <= cmd_nxt.rd;
                    sel_q <= cmd_nxt.sel;
                    o_ioc <= cmd_nxt.ioc;
                    o_cs  <= sel_onehot(cmd_nxt.sel);
                end
                if (state_q == ST_DATA && sck_rise && bit_cnt_q == CNT_DATA_LAST && !rd_q)
                    o_data_out <= rx_byte;
                // Zeros shift in behind the byte, so MISO returns low after bit 0
                if (state_q == ST_WAIT_DATA && wait_q)
                    tx_q <= mod_data[sel_q];
                else if (sck_fall && bit_cnt_q >= CNT_TX_SHIFT)
                    tx_q <= {tx_q[6:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
`timescale 1ns/1ps
// Scoreboard bench for spi_cmd_decoder: the SPI master task pushes expected
// strobes before each frame; a negedge monitor pops and compares them, and
// also drains posted point checks.
module tb_spi_cmd_decoder;

    localparam int HALF    = 80;  // SCK half period = 8 sys clocks (16x ratio)
    localparam int K_FETCH = 0;
    localparam int K_LOAD  = 1;

    typedef struct {
        int         kind;
        logic [3:0] cs;
        logic [4:0] ioc;
        logic [7:0] dat;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       sck = 1'b0, mosi = 1'b0, cs_b = 1'b1;
    logic       miso, fetch, load;
    logic [4:0] ioc;
    logic [3:0] cs;
    logic [7:0] dout;
    logic [7:0] data_m [4];
    logic [7:0] model_dout = 8'h00;

    exp_t exp_q[$];
    chk_t chk_q[$];
    exp_t e_cur;
    chk_t c_cur;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    spi_cmd_decoder #(.SYNC_STAGES(2)) dut (
        .i_sys_clk(clk), .i_rst_b(rst_b),
        .i_spi_sck(sck), .i_spi_mosi(mosi), .i_spi_cs_b(cs_b),
        .o_spi_miso(miso), .o_ioc(ioc), .o_cs(cs),
        .o_fetch_cmd(fetch), .o_load_cmd(load), .o_data_out(dout),
        .i_data_m0(data_m[0]), .i_data_m1(data_m[1]),
        .i_data_m2(data_m[2]), .i_data_m3(data_m[3])
    );

    // Monitor: compares strobes against the scoreboard and drains point checks
    always @(negedge clk) begin
        if (fetch || load) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_unexpected: got fetch=%0b load=%0b cs=%b, expected no strobe", fetch, load, cs);
            end else begin
                e_cur = exp_q.pop_front();
                if ((fetch && load) || (fetch != (e_cur.kind == K_FETCH)) ||
                    cs !== e_cur.cs || ioc !== e_cur.ioc ||
                    (e_cur.kind == K_LOAD && dout !== e_cur.dat)) begin
                    n_fail++;
                    $display("FAIL strobe: got fetch=%0b load=%0b cs=%b ioc=%0d dout=%02h, expected kind=%0d cs=%b ioc=%0d dout=%02h",
                             fetch, load, cs, ioc, dout, e_cur.kind, e_cur.cs, e_cur.ioc, e_cur.dat);
                end
            end
        end
        while (chk_q.size() > 0) begin
            c_cur = chk_q.pop_front();
            n_tests++;
            if (c_cur.act !== c_cur.exp) begin
                n_fail++;
                $display("FAIL %s: got %0h, expected %0h", c_cur.name, c_cur.act, c_cur.exp);
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic post(input string nm, input logic [31:0] a, input logic [31:0] e);
        chk_t c;
        c.name = nm; c.act = a; c.exp = e;
        chk_q.push_back(c);
    endtask

    // Drive CS low and n SCK pulses; capture MISO just before rises 9..16
    task automatic spi_pulses(input logic [7:0] cmd, input logic [7:0] wd, input int n,
                              output logic [7:0] rb);
        logic [15:0] fr;
        int ph;
        fr = {cmd, wd};
        rb = 8'h00;
        @(negedge clk);
        ph = $urandom_range(1, 7);
        if (ph >= 5) ph += 2;
        #(ph);
        cs_b = 1'b0;
        mosi = fr[15];
        for (int i = 0; i < n; i++) begin
            #(HALF - 1);
            if (i >= 8 && i < 16) rb = {rb[6:0], miso};
            #1 sck = 1'b1;
            #(HALF) sck = 1'b0;
            fr = fr << 1;
            mosi = (i + 1 < 16) ? fr[15] : 1'b1;
        end
    endtask

    task automatic spi_end();
        #(HALF) cs_b = 1'b1;
        mosi = 1'b0;
        #(2 * HALF);
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] wd, input int n);
        logic [7:0] rb;
        logic [1:0] sel;
        exp_t e;
        sel   = cmd[6:5];
        e.cs  = 4'b0001 << sel;
        e.ioc = cmd[4:0];
        e.dat = wd;
        if (cmd[7] && n >= 8) begin
            e.kind = K_FETCH;
            exp_q.push_back(e);
        end
        if (!cmd[7] && n >= 16) begin
            e.kind = K_LOAD;
            exp_q.push_back(e);
            model_dout = wd;
        end
        spi_pulses(cmd, wd, n, rb);
        spi_end();
        if (cmd[7] && n >= 16) post("miso_byte", {24'h0, rb}, {24'h0, data_m[sel]});
        post("cs_idle", {28'h0, cs}, 32'h0);
        post("dout_hold", {24'h0, dout}, {24'h0, model_dout});
        post("miso_idle", {31'h0, miso}, 32'h0);
        post("sb_drained", exp_q.size(), 32'h0);
    endtask

    task automatic reset_mid(input logic [7:0] cmd, input logic [7:0] wd, input int n,
                             input logic [3:0] cs_pre);
        logic [7:0] rb;
        spi_pulses(cmd, wd, n, rb);
        post("cs_pre_rst", {28'h0, cs}, {28'h0, cs_pre});
        @(negedge clk) rst_b = 1'b0;
        #1;
        post("rst_mid_outputs", {12'h0, cs, ioc, dout, fetch, load, miso}, 32'h0);
        model_dout = 8'h00;
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        repeat (20) @(negedge clk);
        post("rst_no_resume_cs", {28'h0, cs}, 32'h0);
        #3 cs_b = 1'b1;
        #(4 * HALF);
        post("rst_no_resume_drain", exp_q.size(), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) data_m[i] = 8'h00;
        repeat (3) @(negedge clk);
        post("reset_outputs", {12'h0, cs, ioc, dout, fetch, load, miso}, 32'h0);
        @(negedge clk) rst_b = 1'b1;
        repeat (10) @(negedge clk);

        data_m[2] = 8'h01;
        run_frame(8'hC0, 8'h00, 16);       // read m2 ioc0
        run_frame(8'h23, 8'h5A, 16);       // write m1 ioc3
        run_frame(8'h23, 8'hA7, 12);       // abort before 16th rise
        data_m[0] = 8'hA5;
        run_frame(8'h80, 8'h00, 16);       // read m0 after abort
        run_frame(8'h4F, 8'hC3, 24);       // write with extra clocks
        data_m[3] = 8'h96;
        run_frame(8'hFF, 8'h00, 24);       // read m3 ioc31 with extra clocks
        data_m[1] = 8'h3C;
        run_frame(8'hBE, 8'h00, 10);       // read aborted after fetch
        run_frame(8'h1F, 8'hFF, 16);       // write m0 ioc31
        reset_mid(8'h23, 8'h11, 5, 4'b0000);
        data_m[1] = 8'h80;
        run_frame(8'hA4, 8'h00, 16);       // read m1 ioc4 after reset
        reset_mid(8'h23, 8'h22, 12, 4'b0010);
        run_frame(8'h23, 8'h5A, 16);

        for (int k = 0; k < 120; k++) begin
            int r, n;
            for (int i = 0; i < 4; i++) data_m[i] = 8'($urandom);
            r = $urandom_range(0, 9);
            n = (r < 6) ? 16 : (r < 8) ? 24 : $urandom_range(1, 15);
            run_frame(8'($urandom), 8'($urandom), n);
        end

        post("final_drain", exp_q.size(), 32'h0);
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
